// File: rtl/mic1_uart_rx.sv
// 8N1 UART receiver with a one-entry holding register and valid/ready output handshake.
// Flags framing errors (stop bit low) and overruns (byte lost to a full holding register).
module mic1_uart_rx #(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_rx_s;
  logic w_tick;
  logic w_xfer;

  assign w_rx_s = r_sync2;
  assign w_tick = (r_cnt == '0);
  // Handshake: a byte moves to the consumer on every cycle where rx_valid and
  // rx_ready are both 1; rx_data is held stable for as long as rx_valid is 1.
  assign w_xfer = r_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ser_rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_xfer) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_cnt   <= HALF_RELOAD;
            r_state <= S_START;
          end
        end
        S_START, S_DATA, S_STOP: begin
          if (!w_tick) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_cnt <= FULL_RELOAD;
            if (r_state == S_START) begin
              // A start bit that is already high again at mid-bit was a glitch.
              if (w_rx_s) begin
                r_state <= S_IDLE;
              end else begin
                r_bit_idx <= 3'd0;
                r_state   <= S_DATA;
              end
            end else if (r_state == S_DATA) begin
              r_shift <= {w_rx_s, r_shift[7:1]};
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
              end
            end else if (w_rx_s) begin
              // Accept the byte if the holding register is empty or draining this cycle.
              if (!r_valid || rx_ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule

// File: doc/mic1_uart_rx.md
MIC1_UART_RX -- requirements
Module: mic1_uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 104, meaning clk cycles per serial bit (12 MHz / 115200 baud); legal range 4 and above.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ser_rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-005 SHALL have port rx_data  output  8  received byte; valid while rx_valid=1.
REQ-006 SHALL have port rx_valid  output  1  holding register contains an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data; a transfer occurs on any cycle with rx_valid=1 and rx_ready=1.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Function
REQ-010 SHALL pass ser_rx through a two-flop synchronizer; all decisions use the second flop output (rx_s).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 SHALL, in IDLE with rx_s=0, load the bit counter with CLK_DIV/2-1 (integer division) and enter START.
REQ-013 SHALL, in START/DATA/STOP, decrement the counter every cycle, sample rx_s when the counter is 0, and reload it with CLK_DIV-1.
REQ-014 SHALL, at the START sample, return to IDLE if rx_s=1 (glitch rejection); otherwise enter DATA with bit index 0.
REQ-015 SHALL shift 8 DATA samples in LSB first; after the 8th sample, enter STOP.
REQ-016 SHALL, at the STOP sample with rx_s=1, deliver the byte per REQ-018 to REQ-020 and enter IDLE.
REQ-017 SHALL, at the STOP sample with rx_s=0, discard the byte, pulse frame_err on the next cycle, and enter WAIT_HIGH; leave WAIT_HIGH only to IDLE when rx_s=1 (a held break yields exactly one frame_err).
REQ-018 SHALL, on delivery with rx_valid=0, load rx_data and set rx_valid on the cycle after the STOP sample.
REQ-019 SHALL, on delivery with rx_valid=1 and rx_ready=1 in the same cycle, load the new byte and keep rx_valid=1, with no overrun.
REQ-020 SHALL, on delivery with rx_valid=1 and rx_ready=0, keep the old rx_data, drop the new byte, and pulse overrun on the next cycle.
REQ-021 SHALL clear rx_valid the cycle after a transfer unless REQ-019 applies.
REQ-022 SHALL hold rx_data stable while rx_valid=1.
REQ-023 SHALL size the counter at $clog2(CLK_DIV) bits and the bit index at 3 bits; neither SHALL wrap outside its defined sequence.
REQ-024 SHALL place the STOP sample CLK_DIV/2 + 9*CLK_DIV cycles after the IDLE cycle in which rx_s=0 was seen.

Reset
REQ-025 SHALL, while reset=1, set both synchronizer flops to 1, state to IDLE, counter and bit index to 0, rx_data to 0x00, and rx_valid, frame_err and overrun to 0.
REQ-026 SHALL abandon any frame in progress on reset, with no pulse output during or after reset for that frame.
REQ-027 SHALL resume start detection on the first cycle after reset deasserts.

Verification (CLK_DIV=8)
REQ-028 Drive 0xA5 with rx_ready=1 -> rx_valid high for 1 cycle, rx_data=0xA5, 77 cycles after rx_s falls; frame_err=0, overrun=0.
REQ-029 Pulse ser_rx low for 3 cycles -> no rx_valid and no frame_err; FSM back in IDLE.
REQ-030 Drive 0x3C with stop bit 0, then hold the line low for 40 cycles -> exactly one frame_err pulse, no rx_valid; the next valid byte 0x81 is received.
REQ-031 Hold rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held and one overrun pulse; then rx_ready=1 for 1 cycle -> rx_valid=0.
REQ-032 Assert reset during data bit 4 of a frame -> outputs equal reset values; then send 0x5A -> 0x5A delivered with no errors.
REQ-033 Send back-to-back 0x00 then 0xFF with rx_ready=1 -> both delivered in order, no errors.
